// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Opcodes, sequencer state encoding and PC helper shared by the
//            16-bit CPU sequencer files.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_JCOND = 4'hC;
  localparam logic [3:0] OP_CALL  = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    COMPARE = 3'd4,
    STACK   = 3'd5,
    STOP    = 3'd6
  } seq_state_e;

  // Wraps silently at 16'hFFFF.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc_val);
    return pc_val + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module   : pc_ras
// Purpose  : Pointer-based return-address LIFO. Only compiled when
//            PC_SEQ_RAS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PC_SEQ_RAS_EN
module pc_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  ptr_q;
  logic [AW:0]  ptr_d;
  logic [AW:0]  top_idx;
  logic [15:0]  mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  // ptr_q counts entries, so it is one wider than the memory index.
  assign full    = (ptr_q == (AW+1)'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign top_idx = ptr_q - {{AW{1'b0}}, 1'b1};
  assign dout    = mem_q[top_idx[AW-1:0]];

  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
    end else if (do_pop) begin
      ptr_d = top_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[ptr_q[AW-1:0]] <= din;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multi-cycle PC / instruction sequencer with fetch and exec
//            handshakes, conditional jumps and optional return-address stack
//            (enabled by defining PC_SEQ_RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [4:0]  cond,
  input  logic        cmp_jump,
  input  logic [15:0] branch_target,
  output logic        exec_valid,
  input  logic        exec_done,
  output logic        halted,
  output logic        seq_err
);

  seq_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        seq_err_q, seq_err_d;
  logic        exec_first_q, exec_first_d;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

`ifdef PC_SEQ_RAS_EN
  logic        ras_push;
  logic        ras_pop;
  logic [15:0] ras_dout;
  logic        ras_full;
  logic        ras_empty;

  pc_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .din     (pc_inc(pc_q)),
    .dout    (ras_dout),
    .full    (ras_full),
    .empty   (ras_empty)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      seq_err_q    <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      seq_err_q    <= seq_err_d;
      exec_first_q <= exec_first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    seq_err_d    = seq_err_q;
    exec_first_d = 1'b0;
`ifdef PC_SEQ_RAS_EN
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (fetch_ack) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_JCOND: state_d = COMPARE;
          OP_CALL, OP_RET: begin
`ifdef PC_SEQ_RAS_EN
            state_d = STACK;
`else
            seq_err_d = 1'b1;
            state_d   = STOP;
`endif
          end
          OP_HALT: state_d = STOP;
          default: begin
            exec_first_d = 1'b1;
            state_d      = EXEC;
          end
        endcase
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = pc_inc(pc_q);
          state_d = FETCH;
        end
      end
      COMPARE: begin
        pc_d    = cmp_jump ? branch_target : pc_inc(pc_q);
        state_d = FETCH;
      end
      STACK: begin
`ifdef PC_SEQ_RAS_EN
        // Overflow/underflow leaves pc and the stack untouched.
        if (opcode == OP_CALL) begin
          if (ras_full) begin
            seq_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            ras_push = 1'b1;
            pc_d     = branch_target;
            state_d  = FETCH;
          end
        end else begin
          if (ras_empty) begin
            seq_err_d = 1'b1;
            state_d   = STOP;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_dout;
            state_d = FETCH;
          end
        end
`else
        seq_err_d = 1'b1;
        state_d   = STOP;
`endif
      end
      STOP: state_d = STOP;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_req  = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH:   fetch_req  = 1'b1;
      EXEC:    exec_valid = exec_first_q;
      STOP:    halted     = 1'b1;
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign cond    = ir_q[4:0];
  assign seq_err = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (both with and
//            without PC_SEQ_RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req;
  logic        fetch_ack = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [4:0]  cond;
  logic        cmp_jump = 1'b0;
  logic [15:0] branch_target = '0;
  logic        exec_valid;
  logic        exec_done = 1'b0;
  logic        halted;
  logic        seq_err;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .RESET_PC  (16'h0010),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .instr         (instr),
    .pc            (pc),
    .ir            (ir),
    .cond          (cond),
    .cmp_jump      (cmp_jump),
    .branch_target (branch_target),
    .exec_valid    (exec_valid),
    .exec_done     (exec_done),
    .halted        (halted),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    int          ack_w;
    int          done_w;
    logic        cj;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
    int          exp_pulses;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a sample point with fetch_req high; returns at the next
  // FETCH or STOP sample point.
  task automatic run_instr(input logic [15:0] ins, input int ack_w, input int done_w,
                           input logic cj, input logic [15:0] tgt,
                           output int pulses, output int cycles);
    int since;
    bit done_loop;
    pulses = 0;
    cycles = 0;
    since  = -1;
    done_loop = 1'b0;
    check("fetch_req_at_start", fetch_req, 1);
    instr = ins;
    cmp_jump = cj;
    branch_target = tgt;
    fetch_ack = 1'b0;
    for (int k = 0; k < ack_w; k++) begin
      @(posedge clk); #1; cycles++;
    end
    fetch_ack = 1'b1;
    @(posedge clk); #1; cycles++;
    // Stray ack with garbage data outside FETCH must be ignored.
    instr = 16'hFFFF;
    for (int k = 0; k < 60; k++) begin
      if (fetch_req || halted) begin
        done_loop = 1'b1;
        break;
      end
      if (exec_valid) begin
        pulses++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      exec_done = (since == done_w);
      @(posedge clk); #1; cycles++;
    end
    fetch_ack = 1'b0;
    exec_done = 1'b0;
    if (!done_loop) check("instr_timeout", 1, 0);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_fetch_req"},  fetch_req, 0);
    check({tag, "_exec_valid"}, exec_valid, 0);
    check({tag, "_halted"},     halted, 0);
    check({tag, "_seq_err"},    seq_err, 0);
    check({tag, "_pc"},         pc, 16'h0010);
    check({tag, "_ir"},         ir, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check({tag, "_boot_no_req"}, fetch_req, 0);
    @(posedge clk); #1;
    check({tag, "_first_req"}, fetch_req, 1);
  endtask

  initial begin
    int pulses, cycles;
    logic [15:0] tmp;

    vecs[0] = '{16'h1234, 2, 3, 1'b0, 16'h0000, 16'h0011, 1, 8};
    vecs[1] = '{16'hC002, 0, 0, 1'b1, 16'h0200, 16'h0200, 0, 3};
    vecs[2] = '{16'hC002, 0, 0, 1'b0, 16'h0300, 16'h0201, 0, 3};
    vecs[3] = '{16'h0000, 0, 0, 1'b0, 16'h0000, 16'h0202, 1, 3};
    vecs[4] = '{16'hC01F, 0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 0, 3};
    vecs[5] = '{16'hC005, 0, 0, 1'b0, 16'h1234, 16'h0000, 0, 3};
    vecs[6] = '{16'h7ABC, 1, 1, 1'b0, 16'h0000, 16'h0001, 1, 5};
    vecs[7] = '{16'hB000, 0, 2, 1'b1, 16'h0800, 16'h0002, 1, 5};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por_pc", pc, 16'h0010);
    check("por_ir", ir, 0);
    check("por_fetch_req", fetch_req, 0);
    check("por_exec_valid", exec_valid, 0);
    check("por_halted", halted, 0);
    check("por_seq_err", seq_err, 0);
    reset_n = 1'b1;
    check("boot_no_req", fetch_req, 0);
    @(posedge clk); #1;
    check("first_fetch_req", fetch_req, 1);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].ins, vecs[i].ack_w, vecs[i].done_w, vecs[i].cj, vecs[i].tgt, pulses, cycles);
      tmp = vecs[i].ins;
      check($sformatf("v%0d_ir", i), ir, tmp);
      check($sformatf("v%0d_cond", i), cond, {27'd0, tmp[4:0]});
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("v%0d_cycles", i), cycles, vecs[i].exp_cycles);
      check($sformatf("v%0d_halted", i), halted, 0);
    end

`ifdef PC_SEQ_RAS_EN
    run_instr(16'hC000, 0, 0, 1'b1, 16'h0005, pulses, cycles);
    check("goto5_pc", pc, 16'h0005);
    run_instr(16'hD000, 0, 0, 1'b0, 16'h0100, pulses, cycles);
    check("call_pc", pc, 16'h0100);
    check("call_cycles", cycles, 3);
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0F00, pulses, cycles);
    check("ret_pc", pc, 16'h0006);
    check("ret_cycles", cycles, 3);
    check("ret_seq_err", seq_err, 0);
    for (int i = 1; i <= 4; i++) begin
      run_instr(16'hD000, 0, 0, 1'b0, 16'(i * 16'h1000), pulses, cycles);
      check($sformatf("nest%0d_pc", i), pc, 16'(i * 16'h1000));
      check($sformatf("nest%0d_halted", i), halted, 0);
    end
    run_instr(16'hD000, 0, 0, 1'b0, 16'h5000, pulses, cycles);
    check("ovf_seq_err", seq_err, 1);
    check("ovf_halted", halted, 1);
    check("ovf_pc", pc, 16'h4000);
`else
    run_instr(16'hD000, 0, 0, 1'b0, 16'h0500, pulses, cycles);
    check("call_dis_seq_err", seq_err, 1);
    check("call_dis_halted", halted, 1);
    check("call_dis_pc", pc, 16'h0002);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("stop_sticky_halted", halted, 1);
    check("stop_no_fetch", fetch_req, 0);

    // Reset out of STOP, then abort mid-fetch and mid-exec.
    apply_reset("rst_stop");
    apply_reset("rst_fetch");
    instr = 16'h1234;
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    @(posedge clk); #1;
    check("pre_abort_exec_valid", exec_valid, 1);
    apply_reset("rst_exec");

    run_instr(16'hF000, 0, 0, 1'b0, 16'h0000, pulses, cycles);
    check("halt_halted", halted, 1);
    check("halt_seq_err", seq_err, 0);
    check("halt_pc", pc, 16'h0010);

    apply_reset("rst_halt");
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0700, pulses, cycles);
    check("ret_empty_seq_err", seq_err, 1);
    check("ret_empty_halted", halted, 1);
    check("ret_empty_pc", pc, 16'h0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
